// File: rtl/axi_counter_bank_if.sv
// AXI4-Lite slave bus bundle for axi_counter_bank (AW/W/B/AR/R channels).
// Latency: none, wires only.
// Backpressure: carries the standard VALID/READY pairs; no buffering.
// Ports: slave modport is the DUT side, master modport is the initiator side.
interface axi_counter_bank_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) ();
  logic [ADDR_W-1:0]   S_AXI_AWADDR;
  logic [2:0]          S_AXI_AWPROT;
  logic                S_AXI_AWVALID;
  logic                S_AXI_AWREADY;
  logic [DATA_W-1:0]   S_AXI_WDATA;
  logic [DATA_W/8-1:0] S_AXI_WSTRB;
  logic                S_AXI_WVALID;
  logic                S_AXI_WREADY;
  logic [1:0]          S_AXI_BRESP;
  logic                S_AXI_BVALID;
  logic                S_AXI_BREADY;
  logic [ADDR_W-1:0]   S_AXI_ARADDR;
  logic [2:0]          S_AXI_ARPROT;
  logic                S_AXI_ARVALID;
  logic                S_AXI_ARREADY;
  logic [DATA_W-1:0]   S_AXI_RDATA;
  logic [1:0]          S_AXI_RRESP;
  logic                S_AXI_RVALID;
  logic                S_AXI_RREADY;

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    input  S_AXI_RREADY,
    output S_AXI_AWREADY, S_AXI_WREADY,
    output S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_ARREADY,
    output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    output S_AXI_RREADY,
    input  S_AXI_AWREADY, S_AXI_WREADY,
    input  S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_ARREADY,
    input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );
endinterface

// File: rtl/axi_counter_bank.sv
// Multi-channel event counter bank with AXI4-Lite registers and coherent snapshot readout.
// Latency: event_in -> counter 1 edge; AW/W accepted 1 cycle after both valid, B the cycle after;
//          AR accepted 1 cycle after ARVALID, R registered the cycle after.
// Backpressure: one outstanding write and one outstanding read; B/R held until BREADY/RREADY.
// Ports: ACLK, ARESET (async active-high), s_axi (AXI4-Lite slave modport),
//        event_in[N_CHANNELS] count pulses, overflow[N_CHANNELS] sticky overflow flags.
// Option: define AXI_COUNTER_BANK_SATURATE_EN to saturate counters at all-ones instead of wrapping.
module axi_counter_bank #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 8,
  parameter int N_CHANNELS         = 4,
  parameter int COUNTER_WIDTH      = 48
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  axi_counter_bank_if.slave     s_axi,
  input  logic [N_CHANNELS-1:0] event_in,
  output logic [N_CHANNELS-1:0] overflow
);

  localparam int N  = N_CHANNELS;
  localparam int W  = COUNTER_WIDTH;
  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int SW = DW / 8;

  // Word index one past the last snapshot register of the last implemented channel.
  localparam int SNAP_END = 4 + 2 * N;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

`ifdef AXI_COUNTER_BANK_SATURATE_EN
  localparam logic SAT_BIT = 1'b1;
`else
  localparam logic SAT_BIT = 1'b0;
`endif

  localparam logic [31:0] ID_VAL = {8'(N_CHANNELS), 8'(COUNTER_WIDTH), SAT_BIT, 15'h0002};

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic          wr_rdy_q, wr_rdy_d;
  logic          bvalid_q, bvalid_d;
  logic [1:0]    bresp_q,  bresp_d;
  logic          rd_rdy_q, rd_rdy_d;
  logic          rvalid_q, rvalid_d;
  logic [DW-1:0] rdata_q,  rdata_d;
  logic [1:0]    rresp_q,  rresp_d;

  logic          glb_en_q, glb_en_d;
  logic [N-1:0]  ch_en_q,  ch_en_d;
  logic [N-1:0]  ovf_q,    ovf_d;
  logic [W-1:0]  cnt_q  [N];
  logic [W-1:0]  cnt_d  [N];
  logic [W-1:0]  snap_q [N];
  logic [W-1:0]  snap_d [N];

  // ---------------------------------------------------------------------------
  // Handshakes and address decode
  // ---------------------------------------------------------------------------
  logic          wr_hs, rd_hs;
  logic [DW-1:0] wmask, wdat_m;
  int            wr_word, rd_word;
  logic          snap_now, clr_now, wr_err;
  logic [N-1:0]  ovf_w1c, ovf_set, inc;
  logic [DW-1:0] rd_data;
  logic          rd_err;
  logic [63:0]   snap_sel;

  // READY is registered and only ever high for one cycle; the register update
  // happens on the edge where READY meets the still-asserted VALIDs.
  assign wr_hs = wr_rdy_q & s_axi.S_AXI_AWVALID & s_axi.S_AXI_WVALID;
  assign rd_hs = rd_rdy_q & s_axi.S_AXI_ARVALID;

  always_comb begin
    wmask = '0;
    for (int b = 0; b < SW; b++) begin
      wmask[b*8 +: 8] = {8{s_axi.S_AXI_WSTRB[b]}};
    end
  end

  assign wdat_m  = s_axi.S_AXI_WDATA & wmask;
  assign wr_word = int'(s_axi.S_AXI_AWADDR >> 2);
  assign rd_word = int'(s_axi.S_AXI_ARADDR >> 2);

  // Write decode: only takes effect on the accepting edge.
  always_comb begin
    glb_en_d = glb_en_q;
    ch_en_d  = ch_en_q;
    ovf_w1c  = '0;
    snap_now = 1'b0;
    clr_now  = 1'b0;
    wr_err   = 1'b0;
    if (wr_hs) begin
      case (wr_word)
        0: begin
          glb_en_d = (glb_en_q & ~wmask[0]) | wdat_m[0];
          snap_now = wdat_m[1];
          clr_now  = wdat_m[2];
        end
        1: ch_en_d = (ch_en_q & ~wmask[N-1:0]) | wdat_m[N-1:0];
        2: wr_err = 1'b0;                       // ID is read-only, write dropped
        3: ovf_w1c = wdat_m[N-1:0];
        default: wr_err = !(wr_word >= 4 && wr_word < SNAP_END);
      endcase
    end
  end

  // Read mux; snapshot slots beyond the implemented channels are unmapped.
  always_comb begin
    rd_data  = '0;
    rd_err   = 1'b0;
    snap_sel = '0;
    case (rd_word)
      0: rd_data = DW'(glb_en_q);               // SNAPSHOT/CLEAR_ALL always read 0
      1: rd_data = DW'(ch_en_q);
      2: rd_data = ID_VAL;
      3: rd_data = DW'(ovf_q);
      default: begin
        if (rd_word >= 4 && rd_word < SNAP_END) begin
          for (int i = 0; i < N; i++) begin
            if (((rd_word - 4) >> 1) == i) begin
              snap_sel = 64'(snap_q[i]);
            end
          end
          // Even words are SNAP_LO, odd words SNAP_HI (zero-extended upper bits).
          rd_data = rd_word[0] ? snap_sel[63:32] : snap_sel[31:0];
        end else begin
          rd_err = 1'b1;
        end
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Counters, snapshots, overflow
  // ---------------------------------------------------------------------------
  assign inc = {N{glb_en_q}} & ch_en_q & event_in;

  always_comb begin
    ovf_set = '0;
    for (int i = 0; i < N; i++) begin
      // Snapshot takes the value before this edge's increment or clear.
      snap_d[i] = snap_now ? cnt_q[i] : snap_q[i];
      cnt_d[i]  = cnt_q[i];
      if (clr_now) begin
        cnt_d[i] = '0;
      end else if (inc[i]) begin
        if (&cnt_q[i]) begin
          ovf_set[i] = 1'b1;
`ifdef AXI_COUNTER_BANK_SATURATE_EN
          cnt_d[i] = cnt_q[i];
`else
          cnt_d[i] = '0;
`endif
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
    // A new overflow on the same edge as its W1C keeps the flag set.
    ovf_d = (ovf_q & ~ovf_w1c) | ovf_set;
  end

  // ---------------------------------------------------------------------------
  // Channel handshake next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_rdy_d = ~wr_rdy_q & s_axi.S_AXI_AWVALID & s_axi.S_AXI_WVALID & ~bvalid_q;
    bvalid_d = bvalid_q;
    bresp_d  = bresp_q;
    if (bvalid_q && s_axi.S_AXI_BREADY) begin
      bvalid_d = 1'b0;
    end
    if (wr_hs) begin
      bvalid_d = 1'b1;
      bresp_d  = wr_err ? RESP_SLVERR : RESP_OKAY;
    end

    rd_rdy_d = ~rd_rdy_q & s_axi.S_AXI_ARVALID & ~rvalid_q;
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    if (rvalid_q && s_axi.S_AXI_RREADY) begin
      rvalid_d = 1'b0;
    end
    if (rd_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_err ? '0 : rd_data;
      rresp_d  = rd_err ? RESP_SLVERR : RESP_OKAY;
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wr_rdy_q <= 1'b0;
      bvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
      rd_rdy_q <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
      glb_en_q <= 1'b0;
      ch_en_q  <= '0;
      ovf_q    <= '0;
      cnt_q    <= '{default: '0};
      snap_q   <= '{default: '0};
    end else begin
      wr_rdy_q <= wr_rdy_d;
      bvalid_q <= bvalid_d;
      bresp_q  <= bresp_d;
      rd_rdy_q <= rd_rdy_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
      glb_en_q <= glb_en_d;
      ch_en_q  <= ch_en_d;
      ovf_q    <= ovf_d;
      cnt_q    <= cnt_d;
      snap_q   <= snap_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign s_axi.S_AXI_AWREADY = wr_rdy_q;
  assign s_axi.S_AXI_WREADY  = wr_rdy_q;
  assign s_axi.S_AXI_BVALID  = bvalid_q;
  assign s_axi.S_AXI_BRESP   = bresp_q;
  assign s_axi.S_AXI_ARREADY = rd_rdy_q;
  assign s_axi.S_AXI_RVALID  = rvalid_q;
  assign s_axi.S_AXI_RDATA   = rdata_q;
  assign s_axi.S_AXI_RRESP   = rresp_q;
  assign overflow            = ovf_q;

  // Protection bits, byte offsets and upper data lanes carry no meaning here.
  logic unused_ok;
  assign unused_ok = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                       s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0],
                       wdat_m, wmask};

endmodule

// File: doc/axi_counter_bank.md
# axi_counter_bank

Multi-channel event counter bank with an AXI4-Lite register interface, the parametrised successor to the single AXI counter peripheral. It counts single-cycle event pulses on `N_CHANNELS` independent inputs into `COUNTER_WIDTH`-bit counters. Counters are read coherently through a software-triggered snapshot. It sits on the reference NIC control bus beside the other AXI4-Lite peripherals and is driven by the AXI VIP master in the block-level bench.

## Interface
- `C_S_AXI_DATA_WIDTH`, 32: bus data width; only 32 is supported.
- `C_S_AXI_ADDR_WIDTH`, 8: byte address width; covers 0x00–0x8F.
- `N_CHANNELS`, 4: number of counters; legal range 1–16.
- `COUNTER_WIDTH`, 48: bits per counter; legal range 1–64.
- `ACLK` in 1: single clock for the whole block.
- `ARESET` in 1: asynchronous, active-high reset.
- `S_AXI_AWADDR/AWPROT/AWVALID/AWREADY`, `S_AXI_WDATA/WSTRB/WVALID/WREADY`, `S_AXI_BRESP/BVALID/BREADY`, `S_AXI_ARADDR/ARPROT/ARVALID/ARREADY`, `S_AXI_RDATA/RRESP/RVALID/RREADY`: standard AXI4-Lite slave.
- `event_in` in N_CHANNELS: one count per channel for each cycle the bit is high.
- `overflow` out N_CHANNELS: sticky overflow flags, same value as the OVF register.

## Operation
- **Register map** (word aligned):
  - 0x00 CTRL: bit0 GLOBAL_EN (R/W). Bit1 SNAPSHOT (write-1, self-clearing, reads 0). Bit2 CLEAR_ALL (write-1, self-clearing, reads 0).
  - 0x04 CH_EN[N-1:0]: R/W; bits at and above N read 0.
  - 0x08 ID: RO, value {N_CHANNELS[7:0], COUNTER_WIDTH[7:0], 16'h0002}.
  - 0x0C OVF[N-1:0]: write-1-to-clear.
  - 0x10+8·i SNAP_LO[i], 0x14+8·i SNAP_HI[i]: RO. SNAP_HI returns bits [COUNTER_WIDTH-1:32] zero-extended, or 0 when COUNTER_WIDTH ≤ 32.
- **Counting**
  - Counter i increments when GLOBAL_EN, CH_EN[i] and event_in[i] are all high at a rising edge.
  - Counters are never directly readable; software reads only the snapshot registers.
- **SNAPSHOT**: copies all counters into SNAP_LO/HI on the edge the write is accepted. The copy is the pre-increment value for that edge.
- **CLEAR_ALL**: zeroes all counters on the accepting edge. Clear beats a same-cycle increment.
  - If SNAPSHOT and CLEAR_ALL are written together, the snapshot captures the pre-clear values.
- **Overflow**
  - An increment at all-ones sets OVF[i].
  - A same-cycle W1C of OVF[i] loses to a new overflow (set wins).
  - Wrap/saturate behaviour: see Configuration.
- **WSTRB**: honoured per byte lane for CTRL, CH_EN and OVF. Writes to RO registers are ignored with BRESP OKAY.
- **Unmapped addresses**: this includes snapshot slots for channels ≥ N_CHANNELS.
  - Reads return RDATA 0 with RRESP SLVERR (2'b10).
  - Writes return BRESP SLVERR.
- **Reset values**: all counters, snapshots, CTRL, CH_EN and OVF are 0; overflow is 0. All READY/VALID outputs are 0, RDATA is 0, and BRESP/RRESP are OKAY.

## Timing
- **Write path**
  - Accepted only when AWVALID and WVALID are both high, with no BVALID pending.
  - AWREADY and WREADY pulse together for exactly one cycle; the register update occurs on that edge.
  - BVALID rises the next cycle and holds until BREADY; no new write is accepted while BVALID is high.
- **Read path**
  - ARREADY pulses for one cycle when ARVALID is high and RVALID is low.
  - RVALID and RDATA are registered the next cycle and held stable until RREADY.
- One outstanding transaction per direction. Reads and writes proceed independently.
  - A read of OVF in the same cycle as its W1C returns the pre-clear value.
- `event_in` to counter update: 1 edge. Counter to SNAP visibility: the SNAPSHOT write edge plus 1 read latency.
- ARESET mid-transaction drops all VALID/READY immediately (asynchronously). No response is issued for the aborted transaction.

## Configuration
- `AXI_COUNTER_BANK_SATURATE_EN` defined: a counter at all-ones holds its value on further increments and sets OVF.
- Macro undefined: the counter wraps to 0 and sets OVF.
- ID bit 15 reads 1 when the macro is defined and 0 otherwise. The version field is then 16'h8002 or 16'h0002.

## Test plan
- Reset, then read ID with N=4, W=48 (macro undefined) -> 32'h04300002, RRESP OKAY. Read 0x90 -> RDATA 0, RRESP SLVERR.
- CTRL=1, CH_EN=4'b0101, drive event_in=4'b1111 for 10 cycles, then SNAPSHOT -> SNAP_LO[0]=10, SNAP_LO[1]=0, SNAP_LO[2]=10, SNAP_LO[3]=0.
- Write CTRL=3'b111 while event_in[0] is continuously high -> the snapshot holds the pre-clear count. The next SNAPSHOT after k enabled cycles reads k.
- W=8, 260 events on ch0 -> without the macro, SNAP_LO[0]=4 and OVF=1. With the macro, SNAP_LO[0]=255 and OVF=1. W1C of 0x0C=1 -> OVF=0.
- Hold BREADY/RREADY low for 5 cycles -> BVALID/RVALID and data stay stable. A second AWVALID is not accepted until the B handshake completes.
- Assert ARESET during a pending read -> RVALID drops at once, and all registers read their reset values after release.
